// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register with registered forwarding selects, load-use stall and bubble insertion.
// Optional macro IDEXE_WB_BYPASS_EN substitutes WB_BusW into the latched operands on a same-cycle WB write.
module id_exe_stage #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] ID_BusA,
    input  logic [DATA_W-1:0] ID_BusB,
    input  logic [DATA_W-1:0] ID_Imm32,
    input  logic [RA_W-1:0]   ID_Rs,
    input  logic [RA_W-1:0]   ID_Rt,
    input  logic [RA_W-1:0]   ID_Rw,
    input  logic              ID_UseRs,
    input  logic              ID_UseRt,
    input  logic              ID_RegWr,
    input  logic              ID_MemtoReg,
    input  logic              ID_MemWr,
    input  logic              ID_ALUSrc,
    input  logic [3:0]        ID_ALUctr,
    input  logic [RA_W-1:0]   MEM_Rw,
    input  logic              MEM_RegWr,
    input  logic [RA_W-1:0]   WB_Rw,
    input  logic              WB_RegWr,
    input  logic [DATA_W-1:0] WB_BusW,
    input  logic              Flush,
    output logic              Stall,
    output logic [DATA_W-1:0] EXE_BusA,
    output logic [DATA_W-1:0] EXE_BusB,
    output logic [DATA_W-1:0] EXE_Imm32,
    output logic [RA_W-1:0]   EXE_Rs,
    output logic [RA_W-1:0]   EXE_Rt,
    output logic [RA_W-1:0]   EXE_Rw,
    output logic              EXE_RegWr,
    output logic              EXE_MemtoReg,
    output logic              EXE_MemWr,
    output logic              EXE_ALUSrc,
    output logic [3:0]        EXE_ALUctr,
    output logic [1:0]        EXE_FwdA,
    output logic [1:0]        EXE_FwdB,
    output logic              EXE_Valid
);

    localparam logic [1:0] FWD_MEM = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_RF  = 2'b10;

    logic [DATA_W-1:0] bus_a_q, bus_a_d, bus_b_q, bus_b_d, imm_q, imm_d;
    logic [RA_W-1:0]   rs_q, rs_d, rt_q, rt_d, rw_q, rw_d;
    logic              regwr_q, regwr_d, memtoreg_q, memtoreg_d, memwr_q, memwr_d;
    logic              alusrc_q, alusrc_d, valid_q, valid_d;
    logic [3:0]        aluctr_q, aluctr_d;
    logic [1:0]        fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [1:0]        sel_a, sel_b;
    logic [DATA_W-1:0] opnd_a, opnd_b;
    logic              hz;

    // The instruction now in EXE will sit in MEM when the ID instruction reaches EXE.
    function automatic logic [1:0] fwd_sel(
        input logic            use_x,
        input logic [RA_W-1:0] src,
        input logic            exe_wr,
        input logic [RA_W-1:0] exe_rw,
        input logic            mem_wr,
        input logic [RA_W-1:0] mem_rw
    );
        if (use_x && src != '0 && exe_wr && exe_rw == src)
            return FWD_MEM;
        else if (use_x && src != '0 && mem_wr && mem_rw == src)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    always_comb begin
        sel_a = fwd_sel(ID_UseRs, ID_Rs, regwr_q & valid_q, rw_q, MEM_RegWr, MEM_Rw);
        sel_b = fwd_sel(ID_UseRt, ID_Rt, regwr_q & valid_q, rw_q, MEM_RegWr, MEM_Rw);
        hz = valid_q && memtoreg_q && rw_q != '0 &&
             ((ID_UseRs && rw_q == ID_Rs) || (ID_UseRt && rw_q == ID_Rt));
        Stall = hz & ~Flush;
    end

`ifdef IDEXE_WB_BYPASS_EN
    always_comb begin
        opnd_a = (WB_RegWr && WB_Rw != '0 && WB_Rw == ID_Rs) ? WB_BusW : ID_BusA;
        opnd_b = (WB_RegWr && WB_Rw != '0 && WB_Rw == ID_Rt) ? WB_BusW : ID_BusB;
    end
`else
    always_comb begin
        opnd_a = ID_BusA;
        opnd_b = ID_BusB;
    end
`endif

    always_comb begin
        bus_a_d    = opnd_a;
        bus_b_d    = opnd_b;
        imm_d      = ID_Imm32;
        rs_d       = ID_Rs;
        rt_d       = ID_Rt;
        rw_d       = ID_Rw;
        regwr_d    = ID_RegWr;
        memtoreg_d = ID_MemtoReg;
        memwr_d    = ID_MemWr;
        alusrc_d   = ID_ALUSrc;
        aluctr_d   = ID_ALUctr;
        fwd_a_d    = sel_a;
        fwd_b_d    = sel_b;
        valid_d    = 1'b1;
        // Flush or load-use: send a bubble; a stalled instruction is held upstream and retried.
        if (Flush || hz) begin
            bus_a_d    = '0;
            bus_b_d    = '0;
            imm_d      = '0;
            rs_d       = '0;
            rt_d       = '0;
            rw_d       = '0;
            regwr_d    = 1'b0;
            memtoreg_d = 1'b0;
            memwr_d    = 1'b0;
            alusrc_d   = 1'b0;
            aluctr_d   = '0;
            fwd_a_d    = FWD_RF;
            fwd_b_d    = FWD_RF;
            valid_d    = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bus_a_q    <= '0;
            bus_b_q    <= '0;
            imm_q      <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rw_q       <= '0;
            regwr_q    <= 1'b0;
            memtoreg_q <= 1'b0;
            memwr_q    <= 1'b0;
            alusrc_q   <= 1'b0;
            aluctr_q   <= '0;
            fwd_a_q    <= FWD_RF;
            fwd_b_q    <= FWD_RF;
            valid_q    <= 1'b0;
        end else begin
            bus_a_q    <= bus_a_d;
            bus_b_q    <= bus_b_d;
            imm_q      <= imm_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rw_q       <= rw_d;
            regwr_q    <= regwr_d;
            memtoreg_q <= memtoreg_d;
            memwr_q    <= memwr_d;
            alusrc_q   <= alusrc_d;
            aluctr_q   <= aluctr_d;
            fwd_a_q    <= fwd_a_d;
            fwd_b_q    <= fwd_b_d;
            valid_q    <= valid_d;
        end
    end

    assign EXE_BusA     = bus_a_q;
    assign EXE_BusB     = bus_b_q;
    assign EXE_Imm32    = imm_q;
    assign EXE_Rs       = rs_q;
    assign EXE_Rt       = rt_q;
    assign EXE_Rw       = rw_q;
    assign EXE_RegWr    = regwr_q;
    assign EXE_MemtoReg = memtoreg_q;
    assign EXE_MemWr    = memwr_q;
    assign EXE_ALUSrc   = alusrc_q;
    assign EXE_ALUctr   = aluctr_q;
    assign EXE_FwdA     = fwd_a_q;
    assign EXE_FwdB     = fwd_b_q;
    assign EXE_Valid    = valid_q;

endmodule
